player_motion: RTL

Game-logic stage between the joystick front end and the VGA renderer.
- Consumes debounced, active-high joystick bits and the VGA vertical-sync signal.
- Once per video frame, updates the player sprite position and a single-bullet projectile.
- Outputs registered coordinates that the VGA pixel generator reads to draw the sprite and bullet.

---
 rtl/dclab_game_pkg.sv | 56 +++++
 rtl/vsync_tick.sv | 33 +++
 rtl/player_motion.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dclab_game_pkg.sv
// Shared types, screen geometry and joystick bit positions for the game-logic stage.
package dclab_game_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } bullet_state_e;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;
    localparam int DIR_FIRE  = 4;

    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int SPRITE_W      = 32;
    localparam int SPRITE_H      = 32;
    localparam int STEP          = 4;
    localparam int BULLET_STEP   = 8;
    localparam int FIRE_COOLDOWN = 15;
    localparam int X_INIT        = 304;
    localparam int Y_INIT        = 440;

    localparam int COOL_W = $clog2(FIRE_COOLDOWN + 1);

    localparam coord_t X_MAX         = coord_t'(SCREEN_W - SPRITE_W);
    localparam coord_t Y_MAX         = coord_t'(SCREEN_H - SPRITE_H);
    localparam coord_t X_RESET       = coord_t'(X_INIT);
    localparam coord_t Y_RESET       = coord_t'(Y_INIT);
    localparam coord_t BULLET_STEP_C = coord_t'(BULLET_STEP);
    localparam coord_t MUZZLE_OFFSET = coord_t'(SPRITE_W / 2);

    localparam logic signed [10:0] STEP_S = 11'(STEP);

    // One axis of player motion: +STEP / -STEP / 0 in 11-bit signed, clamped to [0, max_pos].
    function automatic coord_t clamp_step(coord_t pos, logic dec, logic inc, coord_t max_pos);
        logic signed [10:0] delta;
        logic signed [10:0] sum;
        coord_t             result;
        delta = 11'sd0;
        if (inc && !dec) delta = STEP_S;
        if (dec && !inc) delta = -STEP_S;
        sum = $signed({1'b0, pos}) + delta;
        if (sum < 11'sd0)
            result = '0;
        else if (sum > $signed({1'b0, max_pos}))
            result = max_pos;
        else
            result = sum[9:0];
        return result;
    endfunction

endpackage

// File: rtl/vsync_tick.sv
// Turns the active-low VGA vertical sync from another clock domain into one
// single-cycle tick per frame in the local clock domain.
module vsync_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vsync,
    output logic o_frame_tick
);

    // Flops reset high so the idle-high vsync never looks like a falling edge after reset.
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic tick_reg;

    // Two-flop synchronizer, edge register and registered falling-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
            tick_reg  <= 1'b0;
        end else begin
            sync1_reg <= i_vsync;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            tick_reg  <= prev_reg & ~sync2_reg;
        end
    end

    assign o_frame_tick = tick_reg;

endmodule

// File: rtl/player_motion.sv
// Per-frame game logic: moves the player sprite from the joystick and flies a
// single bullet upward, with a launch cooldown counted in frames.
module player_motion
    import dclab_game_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [4:0] i_dir,
    input  logic       i_vsync,
    input  logic       i_hit,
    output logic       o_frame_tick,
    output logic [9:0] o_player_x,
    output logic [9:0] o_player_y,
    output logic       o_bullet_valid,
    output logic [9:0] o_bullet_x,
    output logic [9:0] o_bullet_y,
    output logic       o_fire_pulse
);

    logic frame_tick;

    vsync_tick u_vsync_tick (
        .clk          (CLOCK_50),
        .rst_n        (RST_N),
        .i_vsync      (i_vsync),
        .o_frame_tick (frame_tick)
    );

    bullet_state_e     state_reg, state_next;
    coord_t            player_x_reg, player_x_next;
    coord_t            player_y_reg, player_y_next;
    coord_t            bullet_x_reg, bullet_x_next;
    coord_t            bullet_y_reg, bullet_y_next;
    logic [COOL_W-1:0] cooldown_reg, cooldown_next;
    logic              fire_pending_reg, fire_pending_next;
    logic              fire_prev_reg;
    logic              fire_pulse_reg;
    logic              launch;

    // A launch needs a frame tick, an idle bullet, a latched request and an expired cooldown.
    assign launch = frame_tick && (state_reg == IDLE) && fire_pending_reg && (cooldown_reg == '0);

    // Bullet state register.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Bullet next state: a hit always wins over the per-frame move.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (launch) state_next = FLY;
            FLY: begin
                if (i_hit)
                    state_next = IDLE;
                else if (frame_tick && (bullet_y_reg < BULLET_STEP_C))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bullet coordinates: loaded from the pre-move player position on launch, stepped up in flight.
    always_comb begin
        bullet_x_next = bullet_x_reg;
        bullet_y_next = bullet_y_reg;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    bullet_x_next = player_x_reg + MUZZLE_OFFSET;
                    bullet_y_next = player_y_reg;
                end
            end
            FLY: begin
                if (!i_hit && frame_tick && (bullet_y_reg >= BULLET_STEP_C))
                    bullet_y_next = bullet_y_reg - BULLET_STEP_C;
            end
            default: ;
        endcase
    end

    // Player movement, cooldown and fire-request bookkeeping for the coming edge.
    always_comb begin
        player_x_next     = player_x_reg;
        player_y_next     = player_y_reg;
        cooldown_next     = cooldown_reg;
        fire_pending_next = fire_pending_reg;
        if (frame_tick) begin
            player_x_next = clamp_step(player_x_reg, i_dir[DIR_LEFT], i_dir[DIR_RIGHT], X_MAX);
            player_y_next = clamp_step(player_y_reg, i_dir[DIR_UP], i_dir[DIR_DOWN], Y_MAX);
            // Every tick consumes the request, so blocked presses are dropped, not queued.
            fire_pending_next = 1'b0;
            if (launch)
                cooldown_next = COOL_W'(FIRE_COOLDOWN);
            else if (cooldown_reg != '0)
                cooldown_next = cooldown_reg - 1'b1;
        end else if (i_dir[DIR_FIRE] && !fire_prev_reg) begin
            fire_pending_next = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            player_x_reg     <= X_RESET;
            player_y_reg     <= Y_RESET;
            bullet_x_reg     <= '0;
            bullet_y_reg     <= '0;
            cooldown_reg     <= '0;
            fire_pending_reg <= 1'b0;
            fire_prev_reg    <= 1'b0;
            fire_pulse_reg   <= 1'b0;
        end else begin
            player_x_reg     <= player_x_next;
            player_y_reg     <= player_y_next;
            bullet_x_reg     <= bullet_x_next;
            bullet_y_reg     <= bullet_y_next;
            cooldown_reg     <= cooldown_next;
            fire_pending_reg <= fire_pending_next;
            fire_prev_reg    <= i_dir[DIR_FIRE];
            fire_pulse_reg   <= launch;
        end
    end

    assign o_frame_tick   = frame_tick;
    assign o_player_x     = player_x_reg;
    assign o_player_y     = player_y_reg;
    assign o_bullet_valid = (state_reg == FLY);
    assign o_bullet_x     = bullet_x_reg;
    assign o_bullet_y     = bullet_y_reg;
    assign o_fire_pulse   = fire_pulse_reg;

endmodule
